// File: rtl/fpu_scheduler.sv
// Float register scoreboard and writeback-port scheduler for a fixed-latency FPU.
// Shares the single float-regfile write port with loads; the FPU always gets the port first.
module fpu_scheduler #(
  parameter int LATENCY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic [5:0] issue_op,
  input  logic [4:0] issue_fs,
  input  logic [4:0] issue_ft,
  input  logic [4:0] issue_fd,
  output logic       issue_stall,
  output logic       fpu_go,
  input  logic       ld_valid,
  input  logic [4:0] ld_addr,
  output logic       ld_ready,
  output logic       wb_en,
  output logic [4:0] wb_addr,
  output logic [1:0] wb_sel,
  output logic       wb_lsrc,
  output logic       busy
);
  // The writeback register is the final stage, so only LATENCY-1 stages live here.
  localparam int STAGES = LATENCY - 1;

  logic [31:0]      pending, pending_nxt;
  logic [STAGES:1]  vld_pipe;
  logic [4:0]       fd_pipe  [STAGES:1];
  logic [1:0]       sel_pipe [STAGES:1];
  logic             fpu_op, uses_ft, ld_hit;
  logic [1:0]       code;

  always_comb begin
    fpu_op  = (issue_op[5:3] == 3'b110) && (issue_op[2:1] != 2'b11);
    uses_ft = fpu_op && !issue_op[2];
    case (issue_op[2:0])
      3'd0, 3'd1: code = 2'd0;
      3'd2, 3'd3: code = 2'd1;
      3'd4:       code = 2'd2;
      default:    code = 2'd3;
    endcase
  end

  // Last stage valid means the FPU owns the write port next cycle.
  assign ld_ready = ~vld_pipe[STAGES] & ~pending[ld_addr];
  assign ld_hit   = ld_valid & ld_ready &
                    ((ld_addr == issue_fs) | (uses_ft & (ld_addr == issue_ft)) | (ld_addr == issue_fd));
  assign issue_stall = issue_valid & fpu_op &
                       (pending[issue_fs] | (uses_ft & pending[issue_ft]) | pending[issue_fd] | ld_hit);
  assign fpu_go = issue_valid & fpu_op & ~issue_stall;

  // Set after clear so a set always wins on the same bit.
  always_comb begin
    pending_nxt = pending;
    if (wb_en && !wb_lsrc) pending_nxt[wb_addr] = 1'b0;
    if (fpu_go)            pending_nxt[issue_fd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      busy     <= 1'b0;
      vld_pipe <= '0;
    end else begin
      pending     <= pending_nxt;
      busy        <= |pending_nxt;
      vld_pipe[1] <= fpu_go;
      for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    fd_pipe[1]  <= issue_fd;
    sel_pipe[1] <= code;
    for (int i = 2; i <= STAGES; i++) begin
      fd_pipe[i]  <= fd_pipe[i-1];
      sel_pipe[i] <= sel_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_sel  <= '0;
      wb_lsrc <= 1'b0;
    end else if (vld_pipe[STAGES]) begin
      wb_en   <= 1'b1;
      wb_addr <= fd_pipe[STAGES];
      wb_sel  <= sel_pipe[STAGES];
      wb_lsrc <= 1'b0;
    end else if (ld_valid && ld_ready) begin
      wb_en   <= 1'b1;
      wb_addr <= ld_addr;
      wb_sel  <= 2'd3;
      wb_lsrc <= 1'b1;
    end else begin
      wb_en   <= 1'b0;
    end
  end
endmodule
